// File: rtl/decode_stage.sv
// decode_stage: RISC-V ID stage with register file, decoder, immediate generator and ID/EX register
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] pc4,
  input  logic              stall,
  input  logic              flush,
  input  logic              regwrite_w,
  input  logic [REG_AW-1:0] rd_w,
  input  logic [DATA_W-1:0] result_w,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [DATA_W-1:0] imm_e,
  output logic [DATA_W-1:0] pc_e,
  output logic [DATA_W-1:0] pc4_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic              regwrite_e,
  output logic              alusrc_e,
  output logic              memwrite_e,
  output logic              branch_e,
  output logic              jump_e,
  output logic [1:0]        resultsrc_e,
  output logic [2:0]        alucontrol_e,
  output logic              valid_e,
  output logic              illegal_e
);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011, ALU_SLT = 3'b101;
  localparam int IDEX_W = 5 * DATA_W + 3 * REG_AW + 12;
  logic [DATA_W-1:0] rf [2**REG_AW];
  logic [6:0] op;
  logic [2:0] f3;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [DATA_W-1:0] rd1, rd2, imm, imm_i, imm_s, imm_b, imm_j;
  logic regwrite, alusrc, memwrite, branch, jump, legal, illegal;
  logic [1:0] resultsrc;
  logic [2:0] alu_ri, alucontrol;
  logic [IDEX_W-1:0] d, q;
  assign op  = instruction[6:0];
  assign f3  = instruction[14:12];
  assign rs1 = instruction[15 +: REG_AW];
  assign rs2 = instruction[20 +: REG_AW];
  assign rd  = instruction[7 +: REG_AW];
  assign imm_i = {{(DATA_W-12){instruction[31]}}, instruction[31:20]};
  assign imm_s = {{(DATA_W-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{(DATA_W-12){instruction[31]}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{(DATA_W-20){instruction[31]}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
  // Reads see x0 as zero and forward a same-cycle write-back
  assign rd1 = rs1 == '0 ? '0 : (regwrite_w && rd_w == rs1) ? result_w : rf[rs1];
  assign rd2 = rs2 == '0 ? '0 : (regwrite_w && rd_w == rs2) ? result_w : rf[rs2];
  // Main decoder: control and immediate selection by opcode
  always_comb begin
    regwrite  = 1'b0;
    alusrc    = 1'b0;
    memwrite  = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    resultsrc = 2'b00;
    imm       = '0;
    legal     = 1'b1;
    case (op)
      OP_LW:  begin regwrite = 1'b1; alusrc = 1'b1; resultsrc = 2'b01; imm = imm_i; end
      OP_SW:  begin alusrc = 1'b1; memwrite = 1'b1; imm = imm_s; end
      OP_R:   regwrite = 1'b1;
      OP_I:   begin regwrite = 1'b1; alusrc = 1'b1; imm = imm_i; end
      OP_BEQ: begin branch = 1'b1; imm = imm_b; end
      OP_JAL: begin regwrite = 1'b1; resultsrc = 2'b10; jump = 1'b1; imm = imm_j; end
      default: legal = 1'b0;
    endcase
  end
  assign alu_ri = f3 == 3'b000 ? ((op == OP_R && instruction[30]) ? ALU_SUB : ALU_ADD) :
                  f3 == 3'b010 ? ALU_SLT : f3 == 3'b110 ? ALU_OR : f3 == 3'b111 ? ALU_AND : ALU_ADD;
  assign alucontrol = (op == OP_R || op == OP_I) ? alu_ri : op == OP_BEQ ? ALU_SUB : ALU_ADD;
  assign illegal = !legal && instruction != '0;
  assign d = {rd1, rd2, imm, pc, pc4, rs1, rs2, rd, regwrite, alusrc, memwrite, branch, jump,
              resultsrc, alucontrol, legal, illegal};
  assign {rd1_e, rd2_e, imm_e, pc_e, pc4_e, rs1_e, rs2_e, rd_e, regwrite_e, alusrc_e, memwrite_e,
          branch_e, jump_e, resultsrc_e, alucontrol_e, valid_e, illegal_e} = q;
  // Register file write-back; x0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 2**REG_AW; i++) rf[i] <= '0;
    else if (regwrite_w && rd_w != '0) rf[rd_w] <= result_w;
  end
  // ID/EX register: flush inserts a bubble and beats stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (flush) q <= '0;
    else if (!stall) q <= d;
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized check of decode_stage against a behavioural model
module tb_decode_stage;
  logic clk = 1'b0, rst, stall, flush, regwrite_w;
  logic [31:0] instruction, pc, pc4, result_w;
  logic [4:0] rd_w;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
  logic [4:0] rs1_e, rs2_e, rd_e;
  logic regwrite_e, alusrc_e, memwrite_e, branch_e, jump_e, valid_e, illegal_e;
  logic [1:0] resultsrc_e;
  logic [2:0] alucontrol_e;
  int n_checks = 0, n_fail = 0;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0] rs1, rs2, rd;
    logic regwrite, alusrc, memwrite, branch, jump;
    logic [1:0] resultsrc;
    logic [2:0] alu;
    logic valid, illegal;
  } exp_t;

  exp_t ex;
  logic [31:0] mrf [32];
  logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

  decode_stage dut (
    .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .pc4(pc4), .stall(stall),
    .flush(flush), .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .pc4_e(pc4_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .regwrite_e(regwrite_e), .alusrc_e(alusrc_e),
    .memwrite_e(memwrite_e), .branch_e(branch_e), .jump_e(jump_e), .resultsrc_e(resultsrc_e),
    .alucontrol_e(alucontrol_e), .valid_e(valid_e), .illegal_e(illegal_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int sext(input int v, input int bits);
    return v >= (1 << (bits - 1)) ? v - (1 << bits) : v;
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (regwrite_w && rd_w == a) return result_w;
    return mrf[a];
  endfunction

  function automatic logic [2:0] funct_alu(input bit is_r);
    case (instruction[14:12])
      3'b000:  return (is_r && instruction[30]) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic exp_t decode_model();
    exp_t e = '0;
    int s = $signed(instruction);
    e.rs1 = instruction[19:15];
    e.rs2 = instruction[24:20];
    e.rd  = instruction[11:7];
    e.rd1 = rf_read(instruction[19:15]);
    e.rd2 = rf_read(instruction[24:20]);
    e.pc  = pc;
    e.pc4 = pc4;
    e.valid = 1'b1;
    case (instruction[6:0])
      7'b0000011: begin e.regwrite = 1; e.alusrc = 1; e.resultsrc = 2'b01; e.imm = 32'(s >>> 20); end
      7'b0100011: begin e.memwrite = 1; e.alusrc = 1; e.imm = 32'(((s >>> 25) << 5) | int'(instruction[11:7])); end
      7'b0110011: begin e.regwrite = 1; e.alu = funct_alu(1); end
      7'b0010011: begin e.regwrite = 1; e.alusrc = 1; e.imm = 32'(s >>> 20); e.alu = funct_alu(0); end
      7'b1100011: begin
        e.branch = 1; e.alu = 3'd1;
        e.imm = 32'(sext(int'({instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}), 13));
      end
      7'b1101111: begin
        e.regwrite = 1; e.resultsrc = 2'b10; e.jump = 1;
        e.imm = 32'(sext(int'({instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}), 21));
      end
      default: begin e.valid = 0; e.illegal = instruction != 0; end
    endcase
    return e;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".rd1"}, rd1_e, ex.rd1);
    check({tag, ".rd2"}, rd2_e, ex.rd2);
    check({tag, ".imm"}, imm_e, ex.imm);
    check({tag, ".pc"}, pc_e, ex.pc);
    check({tag, ".pc4"}, pc4_e, ex.pc4);
    check({tag, ".rs1"}, 32'(rs1_e), 32'(ex.rs1));
    check({tag, ".rs2"}, 32'(rs2_e), 32'(ex.rs2));
    check({tag, ".rd"}, 32'(rd_e), 32'(ex.rd));
    check({tag, ".ctrl"}, 32'({regwrite_e, alusrc_e, memwrite_e, branch_e, jump_e}),
          32'({ex.regwrite, ex.alusrc, ex.memwrite, ex.branch, ex.jump}));
    check({tag, ".resultsrc"}, 32'(resultsrc_e), 32'(ex.resultsrc));
    check({tag, ".alucontrol"}, 32'(alucontrol_e), 32'(ex.alu));
    check({tag, ".valid"}, 32'(valid_e), 32'(ex.valid));
    check({tag, ".illegal"}, 32'(illegal_e), 32'(ex.illegal));
  endtask

  task automatic step(input string tag);
    exp_t nx = decode_model();
    @(posedge clk);
    if (flush) ex = '0;
    else if (!stall) ex = nx;
    if (regwrite_w && rd_w != 0) mrf[rd_w] = result_w;
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] tmp;
    rst = 1; instruction = 32'h00528333; pc = 32'h100; pc4 = 32'h104;
    stall = 0; flush = 0; regwrite_w = 0; rd_w = 0; result_w = 0;
    ex = '0;
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    @(posedge clk); #1;
    compare_all("reset");
    rst = 0;
    for (int i = 1; i < 32; i++) begin
      instruction = {7'b0, 5'(i), 5'(i), 3'b000, 5'd6, 7'b0110011};
      step("zero_read");
    end
    regwrite_w = 1; rd_w = 5; result_w = 32'hDEADBEEF; instruction = 0;
    step("wb");
    regwrite_w = 0; instruction = 32'h00528333;
    step("wtr");
    check("wtr_rd1_const", rd1_e, 32'hDEADBEEF);
    check("wtr_rd_const", 32'(rd_e), 32'd6);
    check("wtr_valid_const", 32'(valid_e), 32'd1);
    regwrite_w = 1; rd_w = 5; result_w = 32'h12345678;
    step("bypass");
    check("bypass_rd2_const", rd2_e, 32'h12345678);
    rd_w = 0; result_w = 32'hFFFFFFFF; instruction = 0;
    step("x0_write");
    regwrite_w = 0; instruction = 32'h00000333;
    step("x0_read");
    check("x0_rd1_const", rd1_e, 32'h0);
    instruction = 32'hFFC12083;
    step("lw");
    check("lw_imm_const", imm_e, 32'hFFFFFFFC);
    check("lw_resultsrc_const", 32'(resultsrc_e), 32'd1);
    instruction = 32'hFE000CE3;
    step("beq");
    check("beq_imm_const", imm_e, 32'hFFFFFFF8);
    check("beq_alu_const", 32'(alucontrol_e), 32'd1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      instruction = 32'h00528333 + 32'(i << 7);
      step("stall");
      check("stall_imm_const", imm_e, 32'hFFFFFFF8);
    end
    flush = 1;
    step("flush_stall");
    check("flush_valid_const", 32'(valid_e), 32'd0);
    stall = 0; flush = 0; instruction = 32'h0000007F;
    step("illegal");
    check("illegal_const", 32'(illegal_e), 32'd1);
    instruction = 32'h00528333;
    step("pre_rst");
    stall = 1;
    @(negedge clk);
    rst = 1;
    #1;
    ex = '0;
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    compare_all("rst_async");
    @(posedge clk); #1;
    compare_all("rst_held");
    rst = 0; stall = 0;
    for (int n = 0; n < 400; n++) begin
      tmp = $urandom();
      case ($urandom_range(0, 9))
        0: instruction = 0;
        1: instruction = tmp;
        default: begin tmp[6:0] = ops[$urandom_range(0, 5)]; instruction = tmp; end
      endcase
      regwrite_w = 1'($urandom_range(0, 1));
      rd_w = 5'($urandom());
      result_w = $urandom();
      stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 7) == 0;
      pc = $urandom();
      pc4 = pc + 4;
      step("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage RISC-V pipeline; consumer end of the fetch stage's IF/ID outputs (instruction, pc, pc4).
- Decodes the instruction, generates the immediate and reads a 32x32 register file with a write-back port.
- Registers everything into the ID/EX pipeline register, with stall and flush (flush is driven by the execute-stage redirect, the same pcsrc that steers fetch).

Parameters:
- DATA_W, 32, datapath/register width
- REG_AW, 5, register address width (2**REG_AW registers)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- instruction  in  DATA_W  IF/ID instruction
- pc  in  DATA_W  IF/ID pc
- pc4  in  DATA_W  IF/ID pc+4
- stall  in  1  hold ID/EX register
- flush  in  1  load bubble into ID/EX register
- regwrite_w  in  1  write-back enable
- rd_w  in  REG_AW  write-back destination
- result_w  in  DATA_W  write-back data
- rd1_e, rd2_e  out  DATA_W  rs1/rs2 read data
- imm_e  out  DATA_W  sign-extended immediate
- pc_e, pc4_e  out  DATA_W  pipelined pc/pc+4
- rs1_e, rs2_e, rd_e  out  REG_AW  register fields (for hazard unit)
- regwrite_e, alusrc_e, memwrite_e, branch_e, jump_e  out  1  control
- resultsrc_e  out  2  00 ALU, 01 memory, 10 pc4
- alucontrol_e  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- valid_e  out  1  ID/EX holds a real instruction
- illegal_e  out  1  unsupported non-zero opcode decoded

Behaviour:
- Reset (async, rst=1): every output 0 immediately; all register-file entries cleared to 0. First load at the first rising clk after rst falls.
- Register file:
  - x0 reads 0 always; writes to x0 ignored.
  - Write at rising clk when regwrite_w=1 and rd_w!=0.
  - Read bypass: if regwrite_w=1, rd_w!=0 and rd_w equals rs1/rs2, the read returns result_w in the same cycle.
- Decode, by opcode (regwrite, immsrc, alusrc, memwrite, resultsrc, branch, jump):
  - lw 0000011 = 1,I,1,0,01,0,0
  - sw 0100011 = 0,S,1,1,00,0,0
  - R 0110011 = 1,-,0,0,00,0,0
  - I-ALU 0010011 = 1,I,1,0,00,0,0
  - beq 1100011 = 0,B,0,0,00,1,0
  - jal 1101111 = 1,J,0,0,10,0,1
- Immediates (all sign-extended from instruction[31]):
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[19:12],[20],[30:21],0}
  - R-type: imm=0.
- ALU control:
  - lw/sw/jal -> add; beq -> sub.
  - R/I by funct3: 000 add (sub only for R with funct7[5]=1), 010 slt, 110 or, 111 and.
  - Other funct3 -> add.
- Illegal/bubble:
  - All-zero instruction is a bubble: control 0, valid 0, illegal 0.
  - Any other unlisted opcode: control 0, valid 0, illegal 1.
- ID/EX register, latency 1 cycle. Priority per edge: rst > flush > stall > load.
  - flush: all outputs 0 (bubble); flush wins over simultaneous stall.
  - stall: all outputs hold. Write-back still updates the register file; a held rd1_e/rd2_e is not refreshed.
  - load: all outputs take the decoded values; valid_e=1 for legal instructions.
- Reset mid-stall or mid-flush: reset wins, outputs 0.

Test Plan:
- Reset: rst=1 with instruction=0x00528333 -> all outputs 0; after release, x1..x31 read 0.
- Write-then-read: cycle N regwrite_w=1, rd_w=5, result_w=0xDEADBEEF; cycle N+1 instruction=0x00528333 (add x6,x5,x5) -> next edge: rd1_e=rd2_e=0xDEADBEEF, rd_e=6, regwrite_e=1, alucontrol_e=000, valid_e=1.
- Same-cycle bypass: instruction=0x00528333 while regwrite_w=1, rd_w=5, result_w=0x12345678 -> rd1_e=rd2_e=0x12345678. Write x0=0xFFFFFFFF, then read x0 -> 0.
- Immediates:
  - 0xFFC12083 (lw x1,-4(x2)) -> imm_e=0xFFFFFFFC, alusrc_e=1, resultsrc_e=01.
  - 0xFE000CE3 (beq x0,x0,-8) -> imm_e=0xFFFFFFF8, branch_e=1, alucontrol_e=001.
- Stall/flush:
  - stall=1 for 3 cycles with changing instruction -> outputs hold.
  - flush=1 with stall=1 -> outputs 0, valid_e=0.
  - instruction=0x0000007F -> illegal_e=1, regwrite_e=0.
